fifo_serializer: RTL and testbench
==================================

Name: fifo_serializer

Overview:
- Downstream consumer of m_fifo. Drains words from the FIFO read side and transmits each one as an asynchronous serial frame on a single line.
- Frame format: start bit (0), WIDTH data bits LSB first, stop bit (1).
- Sits between m_fifo and the off-chip serial pin. Pops the FIFO only when it is ready to start a new frame.

Parameters:
- WIDTH, 8, data word width; must match the upstream m_fifo WIDTH.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal values >=1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = frames may start; 0 = no new pop, but any frame in progress completes.
- fifo_empty  in  1  m_fifo empty.
- fifo_data  in  WIDTH  m_fifo data_out.
- fifo_pop  out  1  m_fifo pop.
- tx  out  1  serial line, idles high.
- busy  out  1  high while a frame is in flight (START, DATA or STOP).
- word_done  out  1  one-cycle pulse in the last cycle of each stop bit.

Behaviour:
- Upstream contract (decided): m_fifo is show-ahead. fifo_data holds the head word whenever fifo_empty=0. A pop sampled at a rising edge removes that word.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, tx=1, busy=0, word_done=0.
  - Shift register and counters cleared.
  - fifo_pop=0 throughout reset.
- States: IDLE, START, DATA, STOP.
- Flop sizing: clk_cnt is max(1,$clog2(CLKS_PER_BIT)) bits; bit_cnt is $clog2(WIDTH+1) bits. CLKS_PER_BIT=1 must work.
- tx is driven from a flop. Its value reflects the current state (START=0, DATA=shreg[0], STOP=1, IDLE=1), glitch-free.
- fifo_pop is combinational, asserted only in a launch cycle:
  - launch cycle = (state==IDLE) or (state==STOP and last clk_cnt cycle), AND enable=1 AND fifo_empty=0.
  - fifo_pop is never asserted while fifo_empty=1.
- At the end of a launch cycle: shreg<=fifo_data, state<=START, clk_cnt<=0, bit_cnt<=0.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles; then shreg shifts right by one and bit_cnt increments.
  - After WIDTH bits, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. word_done=1 in the last of these cycles.
  - Then START if that cycle was a launch cycle (back-to-back frames, zero idle gap).
  - Otherwise IDLE.
- Timing, with the pop at cycle N:
  - Start bit occupies cycles N+1..N+CLKS_PER_BIT.
  - Data bit i occupies cycles N+1+CLKS_PER_BIT*(1+i) onward, for CLKS_PER_BIT cycles.
  - Frame length is CLKS_PER_BIT*(WIDTH+2) cycles.
- Exactly one pop per frame.
- enable is sampled only in IDLE or in the last stop cycle. Toggling it mid-frame has no effect on the current frame.
- FIFO going empty mid-frame has no effect; the word is already captured.
- Reset mid-frame: the in-flight word is discarded, tx returns to 1 immediately, and no pop occurs. After release, normal IDLE behaviour resumes.
- busy=1 in START/DATA/STOP and 0 in IDLE. It stays 1 continuously across back-to-back frames.

Test Plan:
1. Reset: rst_n=0 for 5 clocks, FIFO empty, enable=1 -> tx=1, busy=0, fifo_pop=0 during reset and for 20 cycles after release.
2. Single word, m_fifo DEPTH=4, CLKS_PER_BIT=4: push 0xA5 -> exactly one fifo_pop pulse, then count=0.
   - tx sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
   - word_done once, in cycle 40 after the pop; busy high for 40 cycles.
3. Back-to-back: push 0x06 then 0x2A -> second pop occurs in the last stop cycle of frame 1.
   - Frames are contiguous: 80 busy cycles with no tx=1 idle gap before the second start bit.
   - Data bits decode to 0x06 then 0x2A; count goes 2->1->0.
4. Enable gating: FIFO holds 2 words, enable=0 -> no pop for 50 cycles, tx=1.
   - Then set enable=1 and drop it during data bit 2 -> frame 1 completes, no second pop, count stays 1.
5. Reset mid-frame: assert rst_n=0 during data bit 3 of 0x42 -> tx=1 and busy=0 immediately, without waiting for a clock.
   - After release, with 0x17 queued and enable=1 -> a fresh frame carrying 0x17 starts with a full start bit.
6. CLKS_PER_BIT=1, word 0xFF -> frame of 10 cycles: tx 0 then nine 1s; word_done in cycle 10.

Source files
------------

// File: rtl/fifo_serializer.sv
// Purpose : drains a show-ahead FIFO and sends each word as a start/data/stop serial frame, LSB first.
// Latency : start bit begins the cycle after the pop; each frame lasts CLKS_PER_BIT*(WIDTH+2) cycles.
// Backpr. : pops only when a new frame can start (idle, or last stop cycle for back-to-back frames).
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - allows new frames to launch; a frame in flight always completes
//   fifo_empty - upstream FIFO empty flag
//   fifo_data  - upstream FIFO head word (valid while fifo_empty is low)
//   fifo_pop   - combinational pop, high only in a launch cycle
//   tx         - registered serial line, idles high
//   busy       - high while a frame is in START, DATA or STOP
//   word_done  - one-cycle pulse in the final cycle of each stop bit
module fifo_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             tx,
    output logic             busy,
    output logic             word_done
);

    // Counter widths; a single-cycle bit still needs a 1-bit counter.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic             tx_q,      tx_d;

    logic             clk_last;
    logic             launch;

    assign clk_last = (clk_cnt_q == CLK_LAST);

    // A launch may only happen from IDLE or in the final stop cycle. The
    // rst_n term keeps the pop low while reset holds the FSM in IDLE.
    always_comb begin
        launch = 1'b0;
        if (rst_n && enable && !fifo_empty) begin
            if (state_q == S_IDLE) begin
                launch = 1'b1;
            end else if (state_q == S_STOP && clk_last) begin
                launch = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
            end

            S_START: begin
                if (clk_last) begin
                    state_d   = S_DATA;
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (clk_last) begin
                    clk_cnt_d = '0;
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (clk_last) begin
                    state_d   = S_IDLE;
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Launch overrides the per-state result; it is only ever true in
        // IDLE or in the last stop cycle, so it cannot cut a frame short.
        if (launch) begin
            state_d   = S_START;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            shreg_d   = fifo_data;
        end
    end

    // tx is computed from the next state so the flop always matches the
    // state it is registered alongside, with no combinational path to the pin.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

    assign fifo_pop  = launch;
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign word_done = (state_q == S_STOP) && clk_last;

endmodule

// File: tb/tb_fifo_serializer.sv
// Testbench for fifo_serializer: two lanes (CLKS_PER_BIT=4 and =1), each with
// a queue-based FIFO model, a cycle-level frame reference model and a monitor.
module tb_fifo_serializer;

    logic clk;
    int   n_total;
    int   n_pass;
    bit   lane_done [2];

    typedef struct packed {
        logic tx;
        logic last;
    } exp_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s lane%0d: got %0h, expected %0h at %0t", nm, ln, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int CPB = (g == 0) ? 4 : 1;

        logic       rst_n;
        logic       enable;
        logic       fifo_empty;
        logic [7:0] fifo_data;
        logic       fifo_pop;
        logic       tx;
        logic       busy;
        logic       word_done;

        logic [7:0] fq [$];
        exp_t       expq [$];
        logic       pop_lat;
        int         pop_cnt;

        exp_t       e;
        logic       etx, ebusy, ewd, epop;

        fifo_serializer #(
            .WIDTH        (8),
            .CLKS_PER_BIT (CPB)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .enable     (enable),
            .fifo_empty (fifo_empty),
            .fifo_data  (fifo_data),
            .fifo_pop   (fifo_pop),
            .tx         (tx),
            .busy       (busy),
            .word_done  (word_done)
        );

        // Reference frame: start bit, 8 data bits LSB first, stop bit, each
        // held CPB cycles; the final cycle carries the word_done expectation.
        task automatic push_frame(input logic [7:0] w);
            logic v;
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      v = 1'b0;
                else if (b == 9) v = 1'b1;
                else             v = w[b-1];
                for (int c = 0; c < CPB; c++) begin
                    expq.push_back('{tx: v, last: (b == 9 && c == CPB - 1)});
                end
            end
        endtask

        // Monitor: mid-cycle comparison of every DUT output against the model.
        always @(negedge clk) begin
            if (!rst_n) begin
                expq.delete();
                etx = 1'b1; ebusy = 1'b0; ewd = 1'b0; epop = 1'b0;
            end else begin
                if (expq.size() != 0) begin
                    e     = expq.pop_front();
                    etx   = e.tx;
                    ebusy = 1'b1;
                    ewd   = e.last;
                end else begin
                    etx = 1'b1; ebusy = 1'b0; ewd = 1'b0;
                end
                // A new frame may start when nothing remains of the current one.
                epop = enable && (fq.size() != 0) && (expq.size() == 0);
                if (epop) push_frame(fq[0]);
            end
            chk("tx",        g, tx,        etx);
            chk("busy",      g, busy,      ebusy);
            chk("word_done", g, word_done, ewd);
            chk("fifo_pop",  g, fifo_pop,  epop);
            pop_lat = fifo_pop;
        end

        task automatic upd();
            fifo_empty = (fq.size() == 0);
            fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
        endtask

        task automatic step();
            logic [7:0] tmp;
            @(posedge clk);
            if (pop_lat) begin
                tmp = fq.pop_front();
                pop_cnt++;
            end
            #1;
            upd();
        endtask

        task automatic push(input logic [7:0] w);
            fq.push_back(w);
            upd();
        endtask

        task automatic wait_idle(input int budget);
            int n;
            n = 0;
            while ((fq.size() != 0 || expq.size() != 0 || busy) && n < budget) begin
                step();
                n++;
            end
            chk("idle_timeout", g, (n < budget), 1);
        endtask

        task automatic wait_pop(input int budget, output int n);
            int c0;
            c0 = pop_cnt;
            n  = 0;
            while (pop_cnt == c0 && n < budget) begin
                step();
                n++;
            end
            chk("pop_timeout", g, (n < budget), 1);
        endtask

        task automatic do_reset(input int cycles);
            rst_n = 1'b0;
            repeat (cycles) step();
            rst_n = 1'b1;
        endtask

        if (g == 0) begin : directed
            initial begin
                int p0, n;
                pop_lat = 1'b0; pop_cnt = 0;
                rst_n = 1'b0; enable = 1'b1;
                upd();
                // Reset with FIFO empty, then idle after release.
                do_reset(5);
                repeat (20) step();

                // Single word 0xA5.
                p0 = pop_cnt;
                push(8'hA5);
                wait_idle(200);
                chk("a5_pops",  g, pop_cnt - p0, 1);
                chk("a5_count", g, fq.size(), 0);

                // Back-to-back 0x06, 0x2A: second pop in last stop cycle.
                push(8'h06);
                push(8'h2A);
                wait_pop(50, n);
                chk("b2b_count1", g, fq.size(), 1);
                wait_pop(100, n);
                chk("b2b_gap",    g, n, 40);
                chk("b2b_count0", g, fq.size(), 0);
                wait_idle(200);

                // Enable gating.
                enable = 1'b0;
                push(8'h3C);
                push(8'hC3);
                p0 = pop_cnt;
                repeat (50) step();
                chk("gate_nopop", g, pop_cnt - p0, 0);
                chk("gate_count", g, fq.size(), 2);
                enable = 1'b1;
                wait_pop(10, n);
                repeat (13) step();   // now inside data bit 2
                enable = 1'b0;
                n = 0;
                while ((expq.size() != 0 || busy) && n < 200) begin step(); n++; end
                repeat (10) step();
                chk("gate_pops",   g, pop_cnt - p0, 1);
                chk("gate_count1", g, fq.size(), 1);
                enable = 1'b1;
                wait_idle(200);

                // Reset during data bit 3 of 0x42.
                push(8'h42);
                wait_pop(10, n);
                repeat (17) step();   // now inside data bit 3
                rst_n = 1'b0;
                #1;
                chk("rst_tx",   g, tx,       1);
                chk("rst_busy", g, busy,     0);
                chk("rst_pop",  g, fifo_pop, 0);
                step();
                push(8'h17);
                p0 = pop_cnt;
                repeat (3) step();
                chk("rst_hold_nopop", g, pop_cnt - p0, 0);
                rst_n = 1'b1;
                wait_idle(200);
                chk("rst_17_pops", g, pop_cnt - p0, 1);

                // Randomised traffic with random enable.
                for (int i = 0; i < 600; i++) begin
                    if ($urandom_range(0, 3) == 0 && fq.size() < 4) push(8'($urandom));
                    enable = ($urandom_range(0, 7) != 0);
                    step();
                end
                enable = 1'b1;
                wait_idle(1000);
                lane_done[g] = 1'b1;
            end
        end else begin : fast
            initial begin
                int p0;
                pop_lat = 1'b0; pop_cnt = 0;
                rst_n = 1'b0; enable = 1'b1;
                upd();
                do_reset(3);
                repeat (5) step();

                // 0xFF at one clock per bit: start then nine high cycles.
                p0 = pop_cnt;
                push(8'hFF);
                wait_idle(50);
                chk("ff_pops", g, pop_cnt - p0, 1);

                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 2) == 0 && fq.size() < 4) push(8'($urandom));
                    enable = ($urandom_range(0, 5) != 0);
                    step();
                end
                enable = 1'b1;
                wait_idle(500);
                lane_done[g] = 1'b1;
            end
        end
    end

    initial begin
        int cyc;
        n_total = 0;
        n_pass  = 0;
        cyc     = 0;
        while (!(lane_done[0] && lane_done[1]) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        chk("run_timeout", 0, (cyc < 50000), 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
